// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, the empty-label constant and the reservation
// station entry record, plus a CDB tag-match helper used on both the capture
// and the issue-bypass paths.
package tomasulo_pkg;

    localparam int LABEL_W = 5;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 6;

    localparam logic [LABEL_W-1:0] NO_LABEL = 5'd0;

    typedef struct packed {
        logic               busy;
        logic [SEL_W-1:0]   sel_alu;
        logic [LABEL_W-1:0] label1;
        logic [DATA_W-1:0]  value1;
        logic [LABEL_W-1:0] label2;
        logic [DATA_W-1:0]  value2;
    } rs_entry_t;

    // A waiting operand picks up the broadcast only for a real (nonzero) tag.
    function automatic logic label_hit(
        input logic [LABEL_W-1:0] label,
        input logic               cdb_valid,
        input logic [LABEL_W-1:0] cdb_tag
    );
        return cdb_valid && (cdb_tag != NO_LABEL) && (label == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: purely combinational dispatch picker for the reservation station.
// Default build grants the lowest-index ready entry. With RS_OLDEST_FIRST_EN
// defined it takes the age matrix (row i bit j = entry i older than entry j)
// and grants the ready entry that is older than every other ready entry.
module rs_select #(
    parameter int DEPTH = 4
) (
`ifdef RS_OLDEST_FIRST_EN
    input  logic [DEPTH*DEPTH-1:0] age,
`endif
    input  logic [DEPTH-1:0]       ready,
    output logic [DEPTH-1:0]       grant,
    output logic                   any_grant
);

    logic [DEPTH-1:0] grant_s;

`ifdef RS_OLDEST_FIRST_EN
    logic older_s;

    // Grant the ready entry that beats every other ready entry on age.
    always_comb begin
        grant_s = {DEPTH{1'b0}};
        older_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older_s = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                older_s = older_s & ((j == i) || !ready[j] || age[i*DEPTH+j]);
            end
            grant_s[i] = older_s;
        end
    end
`else
    logic found_s;

    // Grant the lowest-index ready entry.
    always_comb begin
        grant_s = {DEPTH{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_s[i] = ready[i] & ~found_s;
            found_s    = found_s | ready[i];
        end
    end
`endif

    assign grant     = grant_s;
    assign any_grant = |grant_s;

endmodule

// File: rtl/reservation_station.sv
// reservation_station: DEPTH-entry station between issue and one functional
// unit. Captures CDB broadcasts into waiting operands (including a bypass for
// the instruction being issued), and presents one ready entry to the unit
// with a valid/ready handshake. Entry i owns tag BASE_TAG+i.
// Optional build macro RS_OLDEST_FIRST_EN switches selection from
// lowest-index to oldest-ready using a DEPTH x DEPTH age matrix.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int BASE_TAG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [SEL_W-1:0]   issue_selALU,
    input  logic [LABEL_W-1:0] issue_label1,
    input  logic [LABEL_W-1:0] issue_label2,
    input  logic [DATA_W-1:0]  issue_value1,
    input  logic [DATA_W-1:0]  issue_value2,
    output logic [LABEL_W-1:0] issue_tag,
    input  logic               cdb_valid,
    input  logic [LABEL_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [SEL_W-1:0]   ex_selALU,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [LABEL_W-1:0] ex_tag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t        entries_r [DEPTH];

    logic [DEPTH-1:0] busy_s;
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] alloc_oh_s;
    logic [DEPTH-1:0] grant_s;
    logic             any_grant_s;
    logic             alloc_found_s;
    logic [IDX_W-1:0] alloc_idx_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             issue_fire_s;
    logic             dispatch_s;
    logic             bypass1_s;
    logic             bypass2_s;

    // Per-entry occupancy and operand readiness from registered state.
    always_comb begin
        busy_s  = {DEPTH{1'b0}};
        ready_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            busy_s[i]  = entries_r[i].busy;
            ready_s[i] = entries_r[i].busy &&
                         (entries_r[i].label1 == NO_LABEL) &&
                         (entries_r[i].label2 == NO_LABEL);
        end
    end

    // Lowest-index free entry is the allocation target.
    always_comb begin
        alloc_oh_s    = {DEPTH{1'b0}};
        alloc_idx_s   = {IDX_W{1'b0}};
        alloc_found_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_s[i] && !alloc_found_s) begin
                alloc_oh_s[i] = 1'b1;
                alloc_idx_s   = IDX_W'(i);
                alloc_found_s = 1'b1;
            end else begin
                alloc_found_s = alloc_found_s;
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [DEPTH*DEPTH-1:0] age_r;

    // Age matrix: a new entry is younger than every entry busy at allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_r <= {(DEPTH*DEPTH){1'b0}};
        end else if (flush) begin
            age_r <= {(DEPTH*DEPTH){1'b0}};
        end else if (issue_fire_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(i) == alloc_idx_s) begin
                        age_r[i*DEPTH+j] <= 1'b0;
                    end else if (IDX_W'(j) == alloc_idx_s) begin
                        age_r[i*DEPTH+j] <= busy_s[i];
                    end
                end
            end
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_select (
        .age       (age_r),
        .ready     (ready_s),
        .grant     (grant_s),
        .any_grant (any_grant_s)
    );
`else
    rs_select #(.DEPTH(DEPTH)) u_select (
        .ready     (ready_s),
        .grant     (grant_s),
        .any_grant (any_grant_s)
    );
`endif

    // Encode the one-hot grant into an entry index for the output mux.
    always_comb begin
        sel_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (grant_s[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    assign issue_ready  = !rst && (|(~busy_s));
    assign issue_tag    = LABEL_W'(BASE_TAG) + LABEL_W'(alloc_idx_s);
    assign issue_fire_s = issue_valid && issue_ready;

    assign ex_valid     = !rst && any_grant_s;
    assign dispatch_s   = ex_valid && ex_ready;
    assign ex_tag       = LABEL_W'(BASE_TAG) + LABEL_W'(sel_idx_s);

    // Presented fields read zero when nothing is eligible.
    always_comb begin
        if (any_grant_s) begin
            ex_selALU = entries_r[sel_idx_s].sel_alu;
            ex_a      = entries_r[sel_idx_s].value1;
            ex_b      = entries_r[sel_idx_s].value2;
        end else begin
            ex_selALU = {SEL_W{1'b0}};
            ex_a      = {DATA_W{1'b0}};
            ex_b      = {DATA_W{1'b0}};
        end
    end

    assign bypass1_s = label_hit(issue_label1, cdb_valid, cdb_tag);
    assign bypass2_s = label_hit(issue_label2, cdb_valid, cdb_tag);

    // Entry storage: reset/flush clear, otherwise allocate, free on dispatch
    // and capture CDB results, all in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire_s && alloc_oh_s[i]) begin
                    entries_r[i].busy    <= 1'b1;
                    entries_r[i].sel_alu <= issue_selALU;
                    entries_r[i].label1  <= bypass1_s ? NO_LABEL : issue_label1;
                    entries_r[i].value1  <= bypass1_s ? cdb_data : issue_value1;
                    entries_r[i].label2  <= bypass2_s ? NO_LABEL : issue_label2;
                    entries_r[i].value2  <= bypass2_s ? cdb_data : issue_value2;
                end else begin
                    if (dispatch_s && grant_s[i]) begin
                        entries_r[i].busy <= 1'b0;
                    end
                    if (entries_r[i].busy &&
                        label_hit(entries_r[i].label1, cdb_valid, cdb_tag)) begin
                        entries_r[i].label1 <= NO_LABEL;
                        entries_r[i].value1 <= cdb_data;
                    end
                    if (entries_r[i].busy &&
                        label_hit(entries_r[i].label2, cdb_valid, cdb_tag)) begin
                        entries_r[i].label2 <= NO_LABEL;
                        entries_r[i].value2 <= cdb_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed bench for reservation_station with
// DEPTH=4, BASE_TAG=1. Covers reset values, issue latency, CDB capture,
// issue bypass, full/reuse, selection order (default or RS_OLDEST_FIRST_EN),
// flush with a concurrent issue, and mid-run reset.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_selALU;
    logic [4:0]  issue_label1;
    logic [4:0]  issue_label2;
    logic [31:0] issue_value1;
    logic [31:0] issue_value2;
    logic [4:0]  issue_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_selALU;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_tag;

    int tests  = 0;
    int failed = 0;

    reservation_station #(.DEPTH(4), .BASE_TAG(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_selALU (issue_selALU),
        .issue_label1 (issue_label1),
        .issue_label2 (issue_label2),
        .issue_value1 (issue_value1),
        .issue_value2 (issue_value2),
        .issue_tag    (issue_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_selALU    (ex_selALU),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_tag       (ex_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction, check the tag it will get, clock it in.
    task automatic issue_chk(input string tag, input logic [4:0] exp_tag,
                             input logic [5:0] sel,
                             input logic [4:0] l1, input logic [31:0] v1,
                             input logic [4:0] l2, input logic [31:0] v2);
        issue_valid  = 1'b1;
        issue_selALU = sel;
        issue_label1 = l1;
        issue_value1 = v1;
        issue_label2 = l2;
        issue_value2 = v2;
        #1;
        check(tag, 32'(issue_tag), 32'(exp_tag));
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [4:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
        cdb_tag   = 5'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_selALU = 6'd0;
        issue_label1 = 5'd0; issue_label2 = 5'd0;
        issue_value1 = 32'd0; issue_value2 = 32'd0;
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_data = 32'd0; ex_ready = 1'b0;

        // Reset behaviour
        tick();
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_issue_ready", 32'(issue_ready), 32'd1);
        check("post_rst_issue_tag", 32'(issue_tag), 32'd1);
        check("post_rst_ex_valid", 32'(ex_valid), 32'd0);
        check("post_rst_ex_sel", 32'(ex_selALU), 32'd0);
        check("post_rst_ex_a", ex_a, 32'd0);
        check("post_rst_ex_b", ex_b, 32'd0);
        check("post_rst_ex_tag", 32'(ex_tag), 32'd1);

        // Ready issue appears the next cycle
        issue_chk("t1_tag", 5'd1, 6'h20, 5'd0, 32'd5, 5'd0, 32'd7);
        check("t1_ex_valid", 32'(ex_valid), 32'd1);
        check("t1_ex_a", ex_a, 32'd5);
        check("t1_ex_b", ex_b, 32'd7);
        check("t1_ex_tag", 32'(ex_tag), 32'd1);
        check("t1_ex_sel", 32'(ex_selALU), 32'h20);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check("t1_drained", 32'(ex_valid), 32'd0);

        // Pending operand resolved by CDB
        ex_ready = 1'b1;
        issue_chk("t2_tag", 5'd1, 6'h01, 5'd3, 32'd0, 5'd0, 32'd9);
        check("t2_wait0", 32'(ex_valid), 32'd0);
        tick();
        check("t2_wait1", 32'(ex_valid), 32'd0);
        ex_ready = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'h11;
        #1;
        check("t2_no_same_cycle", 32'(ex_valid), 32'd0);
        tick();
        cdb_valid = 1'b0; cdb_tag = 5'd0;
        check("t2_ex_valid", 32'(ex_valid), 32'd1);
        check("t2_ex_a", ex_a, 32'h11);
        check("t2_ex_b", ex_b, 32'd9);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // Issue bypass from a same-cycle broadcast
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_data = 32'hAB;
        issue_chk("t3_tag", 5'd1, 6'h02, 5'd0, 32'd1, 5'd2, 32'd0);
        cdb_valid = 1'b0; cdb_tag = 5'd0;
        check("t3_ex_valid", 32'(ex_valid), 32'd1);
        check("t3_ex_b", ex_b, 32'hAB);
        check("t3_ex_a", ex_a, 32'd1);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // Fill, ignore extra issue, free one and reuse its tag
        issue_chk("t4_tag0", 5'd1, 6'h03, 5'd10, 32'd0, 5'd0, 32'd0);
        issue_chk("t4_tag1", 5'd2, 6'h03, 5'd11, 32'd0, 5'd0, 32'd1);
        issue_chk("t4_tag2", 5'd3, 6'h03, 5'd12, 32'd0, 5'd0, 32'd2);
        issue_chk("t4_tag3", 5'd4, 6'h03, 5'd13, 32'd0, 5'd0, 32'd3);
        check("t4_full", 32'(issue_ready), 32'd0);
        issue_valid = 1'b1; issue_label1 = 5'd0; issue_value1 = 32'h55;
        issue_label2 = 5'd0;
        tick();
        issue_valid = 1'b0;
        check("t4_extra_ignored", 32'(ex_valid), 32'd0);
        check("t4_still_full", 32'(issue_ready), 32'd0);
        cdb_pulse(5'd12, 32'h33);
        check("t4_ex_valid", 32'(ex_valid), 32'd1);
        check("t4_ex_tag", 32'(ex_tag), 32'd3);
        check("t4_ex_a", ex_a, 32'h33);
        check("t4_ex_b", ex_b, 32'd2);
        ex_ready = 1'b1;
        #1;
        check("t4_no_same_edge_free", 32'(issue_ready), 32'd0);
        tick();
        ex_ready = 1'b0;
        check("t4_ready_back", 32'(issue_ready), 32'd1);
        check("t4_reuse_tag", 32'(issue_tag), 32'd3);
        check("t4_empty_exec", 32'(ex_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_tag", 32'(issue_tag), 32'd1);

        // Selection order: entry 2 older than entry 0
        issue_chk("t5_tag0", 5'd1, 6'h04, 5'd20, 32'd0, 5'd0, 32'd0);
        issue_chk("t5_tag1", 5'd2, 6'h04, 5'd21, 32'd0, 5'd0, 32'd0);
        issue_chk("t5_tag2", 5'd3, 6'h04, 5'd22, 32'd0, 5'd0, 32'd0);
        cdb_pulse(5'd20, 32'h20);
        check("t5_first_tag", 32'(ex_tag), 32'd1);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        cdb_pulse(5'd22, 32'h22);
        check("t5_e2_tag", 32'(ex_tag), 32'd3);
        issue_chk("t5_realloc", 5'd1, 6'h05, 5'd0, 32'h70, 5'd0, 32'h71);
        check("t5_ex_valid", 32'(ex_valid), 32'd1);
`ifdef RS_OLDEST_FIRST_EN
        check("t5_order_tag", 32'(ex_tag), 32'd3);
        check("t5_order_a", ex_a, 32'h22);
`else
        check("t5_order_tag", 32'(ex_tag), 32'd1);
        check("t5_order_a", ex_a, 32'h70);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Flush with three busy entries and a simultaneous issue
        issue_chk("t6_tag0", 5'd1, 6'h06, 5'd5, 32'd0, 5'd0, 32'd0);
        issue_chk("t6_tag1", 5'd2, 6'h06, 5'd6, 32'd0, 5'd0, 32'd0);
        issue_chk("t6_tag2", 5'd3, 6'h06, 5'd7, 32'd0, 5'd0, 32'd0);
        flush = 1'b1;
        issue_valid = 1'b1; issue_label1 = 5'd0; issue_value1 = 32'd1;
        issue_label2 = 5'd0; issue_value2 = 32'd2;
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        check("t6_issue_ready", 32'(issue_ready), 32'd1);
        check("t6_ex_valid", 32'(ex_valid), 32'd0);
        check("t6_issue_tag", 32'(issue_tag), 32'd1);
        tick();
        check("t6_issue_dropped", 32'(ex_valid), 32'd0);

        // Reset in the middle of operation
        issue_chk("t7_tag0", 5'd1, 6'h07, 5'd0, 32'hA, 5'd0, 32'hB);
        issue_chk("t7_tag1", 5'd2, 6'h07, 5'd9, 32'd0, 5'd0, 32'd0);
        check("t7_pre_valid", 32'(ex_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t7_rst_issue_ready", 32'(issue_ready), 32'd0);
        check("t7_rst_ex_valid", 32'(ex_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t7_issue_ready", 32'(issue_ready), 32'd1);
        check("t7_ex_valid", 32'(ex_valid), 32'd0);
        check("t7_issue_tag", 32'(issue_tag), 32'd1);
        check("t7_ex_a", ex_a, 32'd0);
        check("t7_ex_tag", 32'(ex_tag), 32'd1);
        issue_chk("t7_reissue", 5'd1, 6'h08, 5'd0, 32'h3C, 5'd0, 32'h4D);
        check("t7_reissue_a", ex_a, 32'h3C);
        check("t7_reissue_b", ex_b, 32'h4D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
